// File: rtl/ahb_lite_master_arbiter_if.sv
// Bundle of the requester-side command/response signals and the AHB-Lite
// master bus for the two-requester AHB-Lite master arbiter.
//
// Ports (grouped by role):
//   reqN_valid/ready/write/addr/size/wdata : command channel per requester (N=0,1)
//   rspN_valid/error, rsp_rdata             : completion channel (rdata shared)
//   HADDR/HTRANS/HWRITE/HSIZE/HBURST/HWDATA : AHB-Lite master outputs
//   HRDATA/HREADY/HRESP                     : AHB-Lite master inputs
//
// Modports:
//   master : the arbiter itself (drives the bus, answers the requesters)
//   slave  : the environment around it (requesters plus the AHB slave)
interface ahb_lite_master_arbiter_if #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32
);
    logic                 req0_valid;
    logic                 req0_ready;
    logic                 req0_write;
    logic [ADDRWIDTH-1:0] req0_addr;
    logic [2:0]           req0_size;
    logic [DATAWIDTH-1:0] req0_wdata;

    logic                 req1_valid;
    logic                 req1_ready;
    logic                 req1_write;
    logic [ADDRWIDTH-1:0] req1_addr;
    logic [2:0]           req1_size;
    logic [DATAWIDTH-1:0] req1_wdata;

    logic                 rsp0_valid;
    logic                 rsp0_error;
    logic                 rsp1_valid;
    logic                 rsp1_error;
    logic [DATAWIDTH-1:0] rsp_rdata;

    logic [ADDRWIDTH-1:0] HADDR;
    logic [1:0]           HTRANS;
    logic                 HWRITE;
    logic [2:0]           HSIZE;
    logic [2:0]           HBURST;
    logic [DATAWIDTH-1:0] HWDATA;
    logic [DATAWIDTH-1:0] HRDATA;
    logic                 HREADY;
    logic                 HRESP;

    modport master (
        input  req0_valid, req0_write, req0_addr, req0_size, req0_wdata,
        input  req1_valid, req1_write, req1_addr, req1_size, req1_wdata,
        output req0_ready, req1_ready,
        output rsp0_valid, rsp0_error, rsp1_valid, rsp1_error, rsp_rdata,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output req0_valid, req0_write, req0_addr, req0_size, req0_wdata,
        output req1_valid, req1_write, req1_addr, req1_size, req1_wdata,
        input  req0_ready, req1_ready,
        input  rsp0_valid, rsp0_error, rsp1_valid, rsp1_error, rsp_rdata,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lite_master_arbiter.sv
// Two-requester AHB-Lite master with round-robin arbitration. Each accepted
// command becomes one SINGLE, non-overlapped transfer (IDLE -> ADDR -> DATA
// -> RESP) and a one-cycle completion pulse back to its requester.
//
// Ports:
//   HCLK   : system clock, rising edge
//   HRESET : asynchronous, active-high reset
//   bus    : ahb_lite_master_arbiter_if.master (requester channels + AHB bus)
module ahb_lite_master_arbiter #(
    parameter int ADDRWIDTH = 32,
    parameter int DATAWIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                      HCLK,
    input  logic                      HRESET,
    ahb_lite_master_arbiter_if.master bus
);
    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] WAIT_LAST = CW'(TIMEOUT - 1);
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_RESP} state_t;

    state_t               state_q, state_d;
    logic                 last_q, last_d;   // requester granted most recently / in flight
    logic                 write_q, write_d;
    logic [ADDRWIDTH-1:0] addr_q, addr_d;
    logic [2:0]           size_q, size_d;
    logic [DATAWIDTH-1:0] wdata_q, wdata_d;
    logic [DATAWIDTH-1:0] rdata_q, rdata_d;
    logic                 bad_q, bad_d;     // command rejected without a bus transfer
    logic                 err_q, err_d;
    logic [CW-1:0]        cnt_q, cnt_d;

    logic                 any_valid;
    logic                 grant;
    logic                 sel_write;
    logic [ADDRWIDTH-1:0] sel_addr;
    logic [2:0]           sel_size;
    logic [DATAWIDTH-1:0] sel_wdata;
    logic                 sel_bad;

    // Round robin: on a tie the requester not granted last wins.
    always_comb begin
        any_valid = bus.req0_valid | bus.req1_valid;
        if (bus.req0_valid && bus.req1_valid) begin
            grant = ~last_q;
        end else begin
            grant = bus.req1_valid;
        end
        sel_write = grant ? bus.req1_write : bus.req0_write;
        sel_addr  = grant ? bus.req1_addr  : bus.req0_addr;
        sel_size  = grant ? bus.req1_size  : bus.req0_size;
        sel_wdata = grant ? bus.req1_wdata : bus.req0_wdata;
        sel_bad   = (sel_size > 3'd2)
                 || ((sel_size == 3'd1) && sel_addr[0])
                 || ((sel_size == 3'd2) && (sel_addr[1:0] != 2'b00));
    end

    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        write_d = write_q;
        addr_d  = addr_q;
        size_d  = size_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        bad_d   = bad_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.rsp0_valid = 1'b0;
        bus.rsp1_valid = 1'b0;
        bus.rsp0_error = 1'b0;
        bus.rsp1_error = 1'b0;
        bus.rsp_rdata  = '0;
        bus.HADDR      = '0;
        bus.HTRANS     = HTRANS_IDLE;
        bus.HWRITE     = 1'b0;
        bus.HSIZE      = 3'b000;
        bus.HBURST     = 3'b000;
        bus.HWDATA     = '0;

        case (state_q)
            S_IDLE: begin
                // Ready is suppressed while reset is asserted so no output
                // toggles during reset.
                if (any_valid && !HRESET) begin
                    bus.req0_ready = ~grant;
                    bus.req1_ready = grant;
                    last_d  = grant;
                    write_d = sel_write;
                    addr_d  = sel_addr;
                    size_d  = sel_size;
                    wdata_d = sel_wdata;
                    bad_d   = sel_bad;
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (bad_q) begin
                    // Illegal size/alignment: pass through without a NONSEQ.
                    err_d   = 1'b1;
                    rdata_d = '0;
                    state_d = S_RESP;
                end else begin
                    bus.HTRANS = HTRANS_NONSEQ;
                    bus.HADDR  = addr_q;
                    bus.HWRITE = write_q;
                    bus.HSIZE  = size_q;
                    if (bus.HREADY) begin
                        cnt_d   = '0;
                        state_d = S_DATA;
                    end
                end
            end
            S_DATA: begin
                bus.HADDR  = addr_q;
                bus.HWRITE = write_q;
                bus.HSIZE  = size_q;
                bus.HWDATA = wdata_q;
                if (bus.HREADY) begin
                    rdata_d = write_q ? '0 : bus.HRDATA;
                    err_d   = bus.HRESP;
                    state_d = S_RESP;
                end else begin
                    // The first ERROR cycle (HRESP=1, HREADY=0) is an ordinary
                    // wait here; completion comes with the next HREADY=1.
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == WAIT_LAST) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                        state_d = S_RESP;
                    end
                end
            end
            S_RESP: begin
                bus.rsp0_valid = ~last_q;
                bus.rsp1_valid = last_q;
                bus.rsp0_error = ~last_q & err_q;
                bus.rsp1_error = last_q & err_q;
                bus.rsp_rdata  = rdata_q;
                state_d        = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state_q <= S_IDLE;
            last_q  <= 1'b1;
            write_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= 3'b000;
            wdata_q <= '0;
            rdata_q <= '0;
            bad_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_ahb_lite_master_arbiter.sv
// Testbench for ahb_lite_master_arbiter: directed scenarios plus a randomized
// run checked against a transaction-level reference model.
module tb_ahb_lite_master_arbiter;
    localparam int TIMEOUT = 16;

    logic HCLK = 1'b0;
    logic HRESET;
    int   checks   = 0;
    int   failures = 0;

    ahb_lite_master_arbiter_if ifc ();

    ahb_lite_master_arbiter #(
        .ADDRWIDTH(32),
        .DATAWIDTH(32),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .bus   (ifc)
    );

    always #5 HCLK = ~HCLK;

    typedef struct {
        int          who;
        int          lat;
        int          first_ns;
        bit          err;
        logic [31:0] rd;
        int          nonseq;
        logic [31:0] addr;
        bit          wr;
        logic [2:0]  sz;
        logic [31:0] wd;
        bit          wd_unstable;
        bit          busy_ready;
        bit          rsp_wrong;
    } obs_t;

    task automatic set_req(input int n, input bit v, input bit wr, input logic [31:0] a,
                           input logic [2:0] sz, input logic [31:0] wd);
        if (n == 0) begin
            ifc.req0_valid = v; ifc.req0_write = wr; ifc.req0_addr = a;
            ifc.req0_size = sz; ifc.req0_wdata = wd;
        end else begin
            ifc.req1_valid = v; ifc.req1_write = wr; ifc.req1_addr = a;
            ifc.req1_size = sz; ifc.req1_wdata = wd;
        end
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        ifc.HREADY = 1'b1; ifc.HRESP = 1'b0; ifc.HRDATA = '0;
        repeat (2) @(negedge HCLK);
        #1 HRESET = 1'b0;
    endtask

    // Acts as requester handshake observer plus AHB slave for one transfer.
    // aw: address-phase wait cycles; dw: data-phase wait cycles before the
    // final (or error) response; er: two-cycle ERROR response at the end.
    task automatic serve_one(input int aw, input int dw, input bit er,
                             input logic [31:0] rd, output obs_t o);
        int  t;
        int  dcnt;
        int  acnt;
        int  low;
        bit  dphase;
        o.who = -1; o.lat = -1; o.first_ns = -1; o.err = 0; o.rd = '0;
        o.nonseq = 0; o.addr = '0; o.wr = 0; o.sz = '0; o.wd = '0;
        o.wd_unstable = 0; o.busy_ready = 0; o.rsp_wrong = 0;
        dphase = 0; dcnt = 0; acnt = 0; low = dw + int'(er);
        ifc.HREADY = 1'b1; ifc.HRESP = 1'b0; ifc.HRDATA = rd;
        #1;
        t = 0;
        while (!(ifc.req0_ready || ifc.req1_ready) && t < 60) begin
            @(negedge HCLK); #1;
            t++;
        end
        if (!(ifc.req0_ready || ifc.req1_ready)) return;
        if (ifc.req0_ready && ifc.req1_ready) o.rsp_wrong = 1;
        o.who = ifc.req0_ready ? 0 : 1;
        @(negedge HCLK); #1;
        if (o.who == 0) ifc.req0_valid = 1'b0;
        else            ifc.req1_valid = 1'b0;
        for (int c = 1; c <= 60; c++) begin
            if (ifc.req0_ready || ifc.req1_ready) o.busy_ready = 1;
            if (ifc.rsp0_valid || ifc.rsp1_valid) begin
                if (o.who == 0) begin
                    if (!ifc.rsp0_valid || ifc.rsp1_valid) o.rsp_wrong = 1;
                end else begin
                    if (!ifc.rsp1_valid || ifc.rsp0_valid) o.rsp_wrong = 1;
                end
                o.lat = c;
                o.err = ifc.rsp0_valid ? ifc.rsp0_error : ifc.rsp1_error;
                o.rd  = ifc.rsp_rdata;
                break;
            end
            ifc.HREADY = 1'b1; ifc.HRESP = 1'b0;
            if (ifc.HTRANS == 2'b10) begin
                o.nonseq++;
                if (o.first_ns < 0) begin
                    o.first_ns = c; o.addr = ifc.HADDR; o.wr = ifc.HWRITE; o.sz = ifc.HSIZE;
                end
            end
            if (dphase) begin
                if (dcnt == 0) o.wd = ifc.HWDATA;
                else if (ifc.HWDATA !== o.wd) o.wd_unstable = 1;
                ifc.HREADY = (dcnt >= low);
                ifc.HRESP  = er && (dcnt >= dw);
                dcnt++;
            end else if (ifc.HTRANS == 2'b10) begin
                ifc.HREADY = (acnt >= aw);
                acnt++;
                if (acnt > aw) dphase = 1;
            end
            @(negedge HCLK); #1;
        end
        ifc.HREADY = 1'b1; ifc.HRESP = 1'b0;
    endtask

    task automatic test_reset();
        HRESET = 1'b1;
        set_req(0, 1, 0, 32'h10, 3'd2, 0);
        set_req(1, 1, 1, 32'h20, 3'd2, 32'hFFFF_FFFF);
        ifc.HREADY = 1'b1; ifc.HRESP = 1'b0; ifc.HRDATA = 32'h5555_AAAA;
        @(negedge HCLK); #1;
        checks++; if (ifc.HTRANS !== 2'b00) begin failures++; $display("FAIL reset_htrans: got %0d expected 0", ifc.HTRANS); end
        checks++; if (ifc.req0_ready !== 1'b0 || ifc.req1_ready !== 1'b0) begin failures++; $display("FAIL reset_ready: got %b%b expected 00", ifc.req1_ready, ifc.req0_ready); end
        checks++; if (ifc.rsp0_valid !== 1'b0 || ifc.rsp1_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp: got %b%b expected 00", ifc.rsp1_valid, ifc.rsp0_valid); end
        checks++; if (ifc.HADDR !== 32'h0 || ifc.HWDATA !== 32'h0) begin failures++; $display("FAIL reset_bus: haddr=%h hwdata=%h expected 0", ifc.HADDR, ifc.HWDATA); end
        checks++; if (ifc.HBURST !== 3'b000 || ifc.rsp_rdata !== 32'h0) begin failures++; $display("FAIL reset_misc: hburst=%0d rdata=%h expected 0", ifc.HBURST, ifc.rsp_rdata); end
        do_reset();
    endtask

    task automatic test_single_read();
        obs_t o;
        do_reset();
        set_req(0, 1, 0, 32'h10, 3'd2, 0);
        serve_one(0, 0, 0, 32'hDEAD_BEEF, o);
        checks++; if (o.who !== 0) begin failures++; $display("FAIL read_who: got %0d expected 0", o.who); end
        checks++; if (o.first_ns !== 1) begin failures++; $display("FAIL read_nonseq_cycle: got %0d expected 1", o.first_ns); end
        checks++; if (o.addr !== 32'h10 || o.sz !== 3'd2 || o.wr !== 1'b0) begin failures++; $display("FAIL read_addrphase: addr=%h sz=%0d wr=%0d expected 10/2/0", o.addr, o.sz, o.wr); end
        checks++; if (o.lat !== 3) begin failures++; $display("FAIL read_latency: got %0d expected 3", o.lat); end
        checks++; if (o.rd !== 32'hDEAD_BEEF || o.err !== 1'b0) begin failures++; $display("FAIL read_result: rdata=%h err=%0d expected deadbeef/0", o.rd, o.err); end
        checks++; if (o.rsp_wrong !== 1'b0) begin failures++; $display("FAIL read_rsp_target: got %0d expected 0", o.rsp_wrong); end
        @(negedge HCLK); #1;
        checks++; if (ifc.rsp0_valid !== 1'b0) begin failures++; $display("FAIL read_pulse_width: got %0d expected 0", ifc.rsp0_valid); end
    endtask

    task automatic test_round_robin();
        obs_t o;
        do_reset();
        set_req(0, 1, 0, 32'h100, 3'd2, 0);
        set_req(1, 1, 0, 32'h200, 3'd2, 0);
        serve_one(0, 0, 0, 32'h1111_1111, o);
        checks++; if (o.who !== 0 || o.addr !== 32'h100) begin failures++; $display("FAIL rr_first: who=%0d addr=%h expected 0/100", o.who, o.addr); end
        checks++; if (o.busy_ready !== 1'b0 || o.nonseq !== 1) begin failures++; $display("FAIL rr_no_overlap: busy_ready=%0d nonseq=%0d expected 0/1", o.busy_ready, o.nonseq); end
        serve_one(0, 0, 0, 32'h2222_2222, o);
        checks++; if (o.who !== 1 || o.addr !== 32'h200) begin failures++; $display("FAIL rr_second: who=%0d addr=%h expected 1/200", o.who, o.addr); end
        checks++; if (o.rd !== 32'h2222_2222 || o.rsp_wrong !== 1'b0) begin failures++; $display("FAIL rr_second_rsp: rdata=%h wrong=%0d expected 22222222/0", o.rd, o.rsp_wrong); end
        set_req(0, 1, 0, 32'h104, 3'd2, 0);
        set_req(1, 1, 0, 32'h204, 3'd2, 0);
        serve_one(0, 0, 0, 32'h3333_3333, o);
        checks++; if (o.who !== 0) begin failures++; $display("FAIL rr_next_tie: got %0d expected 0", o.who); end
        serve_one(0, 0, 0, 32'h4444_4444, o);
        checks++; if (o.who !== 1) begin failures++; $display("FAIL rr_drain: got %0d expected 1", o.who); end
    endtask

    task automatic test_write_error();
        obs_t o;
        do_reset();
        set_req(1, 1, 1, 32'h20, 3'd2, 32'hA5A5_A5A5);
        serve_one(0, 2, 1, 32'h7777_7777, o);
        checks++; if (o.who !== 1 || o.wr !== 1'b1) begin failures++; $display("FAIL wr_who: who=%0d hwrite=%0d expected 1/1", o.who, o.wr); end
        checks++; if (o.wd !== 32'hA5A5_A5A5 || o.wd_unstable !== 1'b0) begin failures++; $display("FAIL wr_hwdata: got %h unstable=%0d expected a5a5a5a5/0", o.wd, o.wd_unstable); end
        checks++; if (o.err !== 1'b1 || o.rd !== 32'h0) begin failures++; $display("FAIL wr_error: err=%0d rdata=%h expected 1/0", o.err, o.rd); end
        checks++; if (o.lat !== 6) begin failures++; $display("FAIL wr_latency: got %0d expected 6", o.lat); end
    endtask

    task automatic test_misaligned();
        obs_t o;
        do_reset();
        set_req(0, 1, 0, 32'h02, 3'd2, 0);
        serve_one(0, 0, 0, 32'h9999_9999, o);
        checks++; if (o.nonseq !== 0) begin failures++; $display("FAIL misalign_nonseq: got %0d expected 0", o.nonseq); end
        checks++; if (o.lat !== 2 || o.err !== 1'b1 || o.rd !== 32'h0) begin failures++; $display("FAIL misalign_rsp: lat=%0d err=%0d rdata=%h expected 2/1/0", o.lat, o.err, o.rd); end
        set_req(0, 1, 0, 32'h40, 3'd3, 0);
        serve_one(0, 0, 0, 32'h9999_9999, o);
        checks++; if (o.nonseq !== 0) begin failures++; $display("FAIL size3_nonseq: got %0d expected 0", o.nonseq); end
        checks++; if (o.lat !== 2 || o.err !== 1'b1 || o.rd !== 32'h0) begin failures++; $display("FAIL size3_rsp: lat=%0d err=%0d rdata=%h expected 2/1/0", o.lat, o.err, o.rd); end
    endtask

    task automatic test_timeout();
        obs_t o;
        do_reset();
        set_req(0, 1, 0, 32'h44, 3'd2, 0);
        serve_one(0, 40, 0, 32'h1234_5678, o);
        checks++; if (o.lat !== 2 + TIMEOUT) begin failures++; $display("FAIL timeout_latency: got %0d expected %0d", o.lat, 2 + TIMEOUT); end
        checks++; if (o.err !== 1'b1 || o.rd !== 32'h0) begin failures++; $display("FAIL timeout_rsp: err=%0d rdata=%h expected 1/0", o.err, o.rd); end
        set_req(0, 1, 0, 32'h48, 3'd2, 0);
        serve_one(0, TIMEOUT - 1, 0, 32'h1234_5678, o);
        checks++; if (o.lat !== 3 + TIMEOUT - 1 || o.err !== 1'b0 || o.rd !== 32'h1234_5678) begin failures++; $display("FAIL timeout_edge: lat=%0d err=%0d rdata=%h expected %0d/0/12345678", o.lat, o.err, o.rd, 2 + TIMEOUT); end
    endtask

    task automatic test_reset_mid();
        obs_t o;
        int   seen;
        do_reset();
        set_req(0, 1, 1, 32'h30, 3'd2, 32'h1234_5678);
        ifc.HREADY = 1'b1;
        #1;
        checks++; if (ifc.req0_ready !== 1'b1) begin failures++; $display("FAIL mid_ready: got %0d expected 1", ifc.req0_ready); end
        @(negedge HCLK); #1;
        checks++; if (ifc.HTRANS !== 2'b10) begin failures++; $display("FAIL mid_nonseq: got %0d expected 2", ifc.HTRANS); end
        ifc.req0_valid = 1'b0;
        @(negedge HCLK); #1;
        ifc.HREADY = 1'b0;
        checks++; if (ifc.HWDATA !== 32'h1234_5678) begin failures++; $display("FAIL mid_data_phase: hwdata=%h expected 12345678", ifc.HWDATA); end
        #2 HRESET = 1'b1;
        #1;
        checks++; if (ifc.HTRANS !== 2'b00 || ifc.HWDATA !== 32'h0 || ifc.HADDR !== 32'h0) begin failures++; $display("FAIL mid_reset_bus: htrans=%0d hwdata=%h haddr=%h expected 0", ifc.HTRANS, ifc.HWDATA, ifc.HADDR); end
        @(negedge HCLK); #1;
        HRESET = 1'b0; ifc.HREADY = 1'b1;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (ifc.rsp0_valid || ifc.rsp1_valid) seen++;
            @(negedge HCLK); #1;
        end
        checks++; if (seen !== 0) begin failures++; $display("FAIL mid_no_rsp: got %0d pulses expected 0", seen); end
        set_req(0, 1, 0, 32'h50, 3'd2, 0);
        set_req(1, 1, 0, 32'h60, 3'd2, 0);
        serve_one(0, 0, 0, 32'hCAFE_F00D, o);
        checks++; if (o.who !== 0 || o.lat !== 3 || o.rd !== 32'hCAFE_F00D) begin failures++; $display("FAIL mid_resume: who=%0d lat=%0d rdata=%h expected 0/3/cafef00d", o.who, o.lat, o.rd); end
        serve_one(0, 0, 0, 32'h0, o);
        checks++; if (o.who !== 1) begin failures++; $display("FAIL mid_resume_second: got %0d expected 1", o.who); end
    endtask

    task automatic test_random();
        obs_t        o;
        bit          pend [2];
        bit          pw   [2];
        logic [31:0] pa   [2];
        logic [2:0]  ps   [2];
        logic [31:0] pwd  [2];
        int          last;
        int          w;
        int          aw;
        int          dw;
        int          low;
        int          exp_lat;
        bit          er;
        bit          bad;
        bit          to;
        bit          exp_err;
        logic [31:0] rd;
        logic [31:0] exp_rd;
        do_reset();
        last = 1;
        pend[0] = 0; pend[1] = 0;
        for (int i = 0; i < 60; i++) begin
            for (int n = 0; n < 2; n++) begin
                if (!pend[n] && ($urandom_range(0, 2) != 0)) begin
                    pend[n] = 1;
                    pw[n]   = 1'($urandom_range(0, 1));
                    pa[n]   = $urandom;
                    if ($urandom_range(0, 3) != 0) pa[n][1:0] = 2'b00;
                    ps[n]   = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(3, 7)) : 3'($urandom_range(0, 2));
                    pwd[n]  = $urandom;
                end
            end
            if (!pend[0] && !pend[1]) begin
                pend[0] = 1; pw[0] = 1'b0; pa[0] = 32'h0000_0100; ps[0] = 3'd2; pwd[0] = '0;
            end
            for (int n = 0; n < 2; n++) set_req(n, pend[n], pw[n], pa[n], ps[n], pwd[n]);
            // Reference: grant rule, then outcome from the winner's command
            // and the slave behaviour chosen for this transfer.
            w  = (pend[0] && pend[1]) ? 1 - last : (pend[0] ? 0 : 1);
            aw = $urandom_range(0, 2);
            dw = ($urandom_range(0, 7) == 0) ? $urandom_range(14, 20) : $urandom_range(0, 3);
            er = ($urandom_range(0, 3) == 0);
            rd = $urandom;
            bad = (ps[w] > 3'd2) || (ps[w] == 3'd1 && pa[w][0]) || (ps[w] == 3'd2 && pa[w][1:0] != 2'b00);
            low = dw + int'(er);
            to  = !bad && (low >= TIMEOUT);
            exp_lat = bad ? 2 : (to ? 2 + aw + TIMEOUT : 3 + aw + low);
            exp_err = bad || to || er;
            exp_rd  = (bad || to || pw[w]) ? 32'h0 : rd;
            serve_one(aw, dw, er, rd, o);
            checks++; if (o.who !== w) begin failures++; $display("FAIL rand_grant[%0d]: got %0d expected %0d", i, o.who, w); end
            checks++; if (o.lat !== exp_lat) begin failures++; $display("FAIL rand_latency[%0d]: got %0d expected %0d", i, o.lat, exp_lat); end
            checks++; if (o.err !== exp_err || o.rd !== exp_rd) begin failures++; $display("FAIL rand_rsp[%0d]: err=%0d rdata=%h expected %0d/%h", i, o.err, o.rd, exp_err, exp_rd); end
            checks++; if (o.nonseq !== (bad ? 0 : aw + 1)) begin failures++; $display("FAIL rand_nonseq[%0d]: got %0d expected %0d", i, o.nonseq, bad ? 0 : aw + 1); end
            checks++; if (o.busy_ready !== 1'b0 || o.rsp_wrong !== 1'b0) begin failures++; $display("FAIL rand_protocol[%0d]: busy_ready=%0d rsp_wrong=%0d expected 0/0", i, o.busy_ready, o.rsp_wrong); end
            if (!bad) begin
                checks++; if (o.addr !== pa[w] || o.sz !== ps[w] || o.wr !== pw[w]) begin failures++; $display("FAIL rand_addrphase[%0d]: addr=%h sz=%0d wr=%0d expected %h/%0d/%0d", i, o.addr, o.sz, o.wr, pa[w], ps[w], pw[w]); end
                if (pw[w]) begin
                    checks++; if (o.wd !== pwd[w] || o.wd_unstable !== 1'b0) begin failures++; $display("FAIL rand_hwdata[%0d]: got %h unstable=%0d expected %h/0", i, o.wd, o.wd_unstable, pwd[w]); end
                end
            end
            pend[w] = 0;
            last = w;
        end
        set_req(0, 0, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_round_robin();
        test_write_error();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
